// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl: hex 7-segment driver, static or time-multiplexed with frame-synchronous updates
module seg7_display_ctrl #(
  parameter int DIGITS      = 8,
  parameter int MUX_MODE    = 0,
  parameter int SCAN_DIV    = 50000,
  parameter int GUARD       = 2,
  parameter int ACTIVE_LOW  = 1,
  parameter int SUPPRESS_LZ = 0
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  blank,
  output logic [7*DIGITS-1:0]   seg_static,
  output logic [DIGITS-1:0]     dp_static,
  output logic [6:0]            seg_mux,
  output logic                  dp_mux,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_done
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
  localparam logic INA = ACTIVE_LOW != 0;
  localparam logic SCAN = MUX_MODE != 0;

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [4*DIGITS-1:0]  val_q, val_d, sh_val_q, sh_val_d;
  logic [DIGITS-1:0]    dpr_q, dpr_d, sh_dp_q, sh_dp_d;
  logic                 pend_q, pend_d, wrap;
  logic [7*DIGITS-1:0]  seg_st_d;
  logic [DIGITS-1:0]    dp_st_d, en_d;
  logic [6:0]           seg_mx_d;
  logic                 dp_mx_d, fd_d;

  // {dp, seg} for digit k in output polarity, with leading-zero blanking applied
  function automatic logic [7:0] glyph(input logic [4*DIGITS-1:0] v, input logic [DIGITS-1:0] d, input int k);
    logic [4*DIGITS-1:0] vs;
    logic [DIGITS-1:0] ds;
    logic [6:0] s;
    vs = v >> (4 * k);
    ds = d >> k;
    case (vs[3:0])
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    if (SUPPRESS_LZ != 0 && k != 0 && vs == '0) return {8{INA}};
    return {ds[0], s} ^ {8{INA}};
  endfunction

  always_comb begin
    cnt_d    = '0;
    idx_d    = idx_q;
    wrap     = 1'b0;
    val_d    = val_q;
    dpr_d    = dpr_q;
    sh_val_d = sh_val_q;
    sh_dp_d  = sh_dp_q;
    pend_d   = pend_q;
    seg_st_d = {7*DIGITS{INA}};
    dp_st_d  = {DIGITS{INA}};
    seg_mx_d = {7{INA}};
    dp_mx_d  = INA;
    en_d     = {DIGITS{INA}};
    fd_d     = 1'b0;
    if (SCAN) begin
      cnt_d = cnt_q == CNT_MAX ? '0 : cnt_q + 1'b1;
      idx_d = cnt_q != CNT_MAX ? idx_q : (idx_q == IDX_MAX ? '0 : idx_q + 1'b1);
      wrap  = cnt_q == CNT_MAX && idx_q == IDX_MAX;
      if (load) begin
        sh_val_d = value;
        sh_dp_d  = dp;
        pend_d   = 1'b1;
      end
      // commit only on the frame boundary so a frame never mixes old and new digits
      if (wrap && pend_d) begin
        val_d  = sh_val_d;
        dpr_d  = sh_dp_d;
        pend_d = 1'b0;
      end
      {dp_mx_d, seg_mx_d} = blank ? {8{INA}} : glyph(val_d, dpr_d, int'(idx_d));
      en_d = cnt_d >= CNT_GUARD ? (DIGITS'(1) << idx_d) ^ {DIGITS{INA}} : {DIGITS{INA}};
      fd_d = cnt_d == CNT_MAX && idx_d == IDX_MAX;
    end else begin
      if (load) begin
        val_d = value;
        dpr_d = dp;
      end
      for (int k = 0; k < DIGITS; k++)
        {dp_st_d[k], seg_st_d[7*k +: 7]} = blank ? {8{INA}} : glyph(val_q, dpr_q, k);
    end
  end

  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      val_q      <= '0;
      dpr_q      <= '0;
      sh_val_q   <= '0;
      sh_dp_q    <= '0;
      pend_q     <= 1'b0;
      seg_static <= {7*DIGITS{INA}};
      dp_static  <= {DIGITS{INA}};
      seg_mux    <= {7{INA}};
      dp_mux     <= INA;
      digit_en   <= {DIGITS{INA}};
      frame_done <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      val_q      <= val_d;
      dpr_q      <= dpr_d;
      sh_val_q   <= sh_val_d;
      sh_dp_q    <= sh_dp_d;
      pend_q     <= pend_d;
      seg_static <= seg_st_d;
      dp_static  <= dp_st_d;
      seg_mux    <= seg_mx_d;
      dp_mux     <= dp_mx_d;
      digit_en   <= en_d;
      frame_done <= fd_d;
    end
  end
endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb_seg7_display_ctrl: static, static+LZ and scanned instances checked against a frame-level model
module tb_seg7_display_ctrl;
  typedef struct packed {
    logic [31:0] v;
    logic [7:0]  d;
    logic        bl;
    logic [6:0]  st0, st7, lz0, lz1, lz7;
    logic [7:0]  stdp, lzdp;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1, load = 1'b0, blank = 1'b0;
  logic [31:0] value = '0;
  logic [7:0]  dp = '0;
  logic [55:0] st_seg, lz_seg;
  logic [7:0]  st_dp, lz_dp, st_en, lz_en;
  logic [6:0]  st_smx, lz_smx, sc_smx;
  logic        st_dmx, lz_dmx, sc_dmx, st_fd, lz_fd, sc_fd;
  logic [27:0] sc_seg;
  logic [3:0]  sc_dp, sc_en;
  int          n_chk = 0, n_fail = 0, t = 0, pframe = 0;
  logic [6:0]  glyph [16];
  logic [15:0] shown_v, pend_v;
  logic [3:0]  shown_d, pend_d;
  bit          pv;
  vec_t        tbl [6];
  logic [6:0]  prev0;
  logic [31:0] rv;
  logic [7:0]  rd;

  seg7_display_ctrl #(.DIGITS(8), .MUX_MODE(0), .ACTIVE_LOW(1), .SUPPRESS_LZ(0)) u_st (
    .clk(clk), .reset_in(rst), .value(value), .dp(dp), .load(load), .blank(blank),
    .seg_static(st_seg), .dp_static(st_dp), .seg_mux(st_smx), .dp_mux(st_dmx),
    .digit_en(st_en), .frame_done(st_fd));
  seg7_display_ctrl #(.DIGITS(8), .MUX_MODE(0), .ACTIVE_LOW(1), .SUPPRESS_LZ(1)) u_lz (
    .clk(clk), .reset_in(rst), .value(value), .dp(dp), .load(load), .blank(blank),
    .seg_static(lz_seg), .dp_static(lz_dp), .seg_mux(lz_smx), .dp_mux(lz_dmx),
    .digit_en(lz_en), .frame_done(lz_fd));
  seg7_display_ctrl #(.DIGITS(4), .MUX_MODE(1), .SCAN_DIV(8), .GUARD(2), .ACTIVE_LOW(1), .SUPPRESS_LZ(0)) u_sc (
    .clk(clk), .reset_in(rst), .value(value[15:0]), .dp(dp[3:0]), .load(load), .blank(blank),
    .seg_static(sc_seg), .dp_static(sc_dp), .seg_mux(sc_smx), .dp_mux(sc_dmx),
    .digit_en(sc_en), .frame_done(sc_fd));

  always #5 clk = ~clk;

  // clocks elapsed since reset release: slot = t%8, digit = (t/8)%4, frame = t/32
  always @(posedge clk or posedge rst)
    if (rst) t <= 0;
    else t <= t + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_dig(input logic [31:0] v, input logic [7:0] d, input int k, input bit lz, input bit bl);
    if (bl || (lz && k != 0 && (v >> (4 * k)) == 0)) return 8'hFF;
    return {~d[k], ~glyph[v[4*k +: 4]]};
  endfunction

  task automatic chk_static(input logic [31:0] v, input logic [7:0] d, input bit bl);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("st_dig%0d", k), {st_dp[k], st_seg[7*k +: 7]}, ref_dig(v, d, k, 0, bl));
      chk($sformatf("lz_dig%0d", k), {lz_dp[k], lz_seg[7*k +: 7]}, ref_dig(v, d, k, 1, bl));
    end
    chk("st_mux_idle", {st_smx, st_dmx, st_en, st_fd}, {7'h7F, 1'b1, 8'hFF, 1'b0});
  endtask

  // one scanned cycle: entered and left at posedge+1
  task automatic scan_cycle(input bit ld, input logic [15:0] v, input logic [3:0] d, input bit bl);
    bit blp;
    int idx;
    logic [6:0] es;
    logic edp;
    logic [3:0] een;
    if (pv && pframe < t / 32) begin
      shown_v = pend_v;
      shown_d = pend_d;
      pv = 0;
    end
    blp = blank;
    load = ld; blank = bl; value = {16'h0, v}; dp = {4'h0, d};
    if (ld) begin
      pend_v = v; pend_d = d; pv = 1; pframe = t / 32;
    end
    @(negedge clk);
    idx = (t / 8) % 4;
    es  = (t == 0 || blp) ? 7'h7F : ~glyph[shown_v[4*idx +: 4]];
    edp = (t == 0 || blp) ? 1'b1 : ~shown_d[idx];
    een = (t % 8 >= 2) ? ~(4'b0001 << idx) : 4'hF;
    chk("sc_seg_dp", {sc_smx, sc_dmx}, {es, edp});
    chk("sc_digit_en", sc_en, een);
    chk("sc_frame_done", sc_fd, t % 32 == 31);
    chk("sc_static_idle", {sc_seg, sc_dp}, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  initial begin
    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    tbl[0] = '{32'h0123ABCD, 8'h81, 1'b0, 7'h21, 7'h40, 7'h21, 7'h46, 7'h7F, 8'h7E, 8'hFE};
    tbl[1] = '{32'h000000A0, 8'hFF, 1'b0, 7'h40, 7'h40, 7'h40, 7'h08, 7'h7F, 8'h00, 8'hFC};
    tbl[2] = '{32'h00000000, 8'h03, 1'b0, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h7F, 8'hFC, 8'hFE};
    tbl[3] = '{32'hF0000005, 8'h00, 1'b0, 7'h12, 7'h0E, 7'h12, 7'h40, 7'h0E, 8'hFF, 8'hFF};
    tbl[4] = '{32'h89ABCDEF, 8'h5A, 1'b0, 7'h0E, 7'h00, 7'h0E, 7'h06, 7'h00, 8'hA5, 8'hA5};
    tbl[5] = '{32'h12345678, 8'hFF, 1'b1, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 8'hFF, 8'hFF};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_st", {st_seg, st_dp}, {64{1'b1}});
    chk("rst_st_mux", {st_smx, st_dmx, st_en, st_fd}, {7'h7F, 1'b1, 8'hFF, 1'b0});
    chk("rst_sc", {sc_smx, sc_dmx, sc_en, sc_fd}, {7'h7F, 1'b1, 4'hF, 1'b0});
    chk("rst_sc_static", {sc_seg, sc_dp}, 32'hFFFF_FFFF);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_static(32'h0, 8'h0, 1'b0);
    @(posedge clk); #1;

    prev0 = 7'h40;
    for (int i = 0; i < 6; i++) begin
      load = 1'b1; value = tbl[i].v; dp = tbl[i].d; blank = tbl[i].bl;
      @(posedge clk); #1 load = 1'b0;
      @(negedge clk);
      chk("tbl_n1_d0", st_seg[6:0], tbl[i].bl ? 7'h7F : prev0);
      @(posedge clk);
      @(negedge clk);
      chk("tbl_st0", st_seg[6:0], tbl[i].st0);
      chk("tbl_st7", st_seg[55:49], tbl[i].st7);
      chk("tbl_lz0", lz_seg[6:0], tbl[i].lz0);
      chk("tbl_lz1", lz_seg[13:7], tbl[i].lz1);
      chk("tbl_lz7", lz_seg[55:49], tbl[i].lz7);
      chk("tbl_stdp", st_dp, tbl[i].stdp);
      chk("tbl_lzdp", lz_dp, tbl[i].lzdp);
      prev0 = tbl[i].st0;
      @(posedge clk); #1;
    end
    blank = 1'b0;
    @(negedge clk);
    chk("unblank_lag", st_seg[6:0], 7'h7F);
    @(posedge clk);
    @(negedge clk);
    chk("unblank_d0", st_seg[6:0], 7'h00);
    chk("unblank_dp", st_dp, 8'h00);
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      rv = $urandom >> (4 * $urandom_range(0, 8));
      rd = 8'($urandom);
      load = 1'b1; value = rv; dp = rd;
      @(posedge clk); #1 load = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk_static(rv, rd, 1'b0);
      @(posedge clk); #1;
    end

    rst = 1'b1; load = 1'b1; value = 32'h1111_1111; dp = 8'hFF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; load = 1'b0; value = '0; dp = '0;
    shown_v = '0; shown_d = '0; pv = 0;
    for (int c = 0; c < 160; c++)
      scan_cycle(t == 40 || t == 50 || t == 95,
                 t == 40 ? 16'h1111 : (t == 50 ? 16'h2222 : 16'hA5C3),
                 t == 40 ? 4'h1 : 4'h6, t >= 120 && t < 124);
    for (int c = 0; c < 400; c++)
      scan_cycle($urandom_range(0, 7) == 0, 16'($urandom), 4'($urandom), $urandom_range(0, 15) == 0);

    while (t % 32 != 8) scan_cycle(1'b0, 16'h0, 4'h0, 1'b0);
    scan_cycle(1'b1, 16'h5555, 4'hF, 1'b0);
    scan_cycle(1'b0, 16'h0, 4'h0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_sc", {sc_smx, sc_dmx, sc_en, sc_fd}, {7'h7F, 1'b1, 4'hF, 1'b0});
    chk("midrst_st", {st_seg, st_dp}, {64{1'b1}});
    @(posedge clk); #1 rst = 1'b0;
    shown_v = '0; shown_d = '0; pv = 0;
    for (int c = 0; c < 70; c++) scan_cycle(1'b0, 16'h0, 4'h0, 1'b0);
    @(negedge clk);
    chk_static(32'h0, 8'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
